// File: rtl/multi_timer_if.sv
// Register-window bus of the multi-channel timer.
// Word address, write strobe, write data and read data.
interface multi_timer_if;
  logic [6:2]  PrAddr;
  logic        Wr_en;
  logic [31:0] Data_in;
  logic [31:0] Data_out;

  modport master (
    output PrAddr,
    output Wr_en,
    output Data_in,
    input  Data_out
  );

  modport slave (
    input  PrAddr,
    input  Wr_en,
    input  Data_in,
    output Data_out
  );
endinterface

// File: rtl/multi_timer.sv
// Multi-channel down-counting timer with one-shot,
// auto-reload and PWM modes and a shared IRQ line.
module multi_timer #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  multi_timer_if.slave      bus,
  output logic              IRQ,
  output logic [NUM_CH-1:0] pwm_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT
  } st_e;

  localparam logic [1:0] M_ONE = 2'd0;
  localparam logic [1:0] M_PWM = 2'd2;
  localparam logic [1:0] M_RSV = 2'd3;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_ZERO = '0;

  logic [4:0]       word;
  logic [3:0]       ctrl   [NUM_CH];
  logic [CNT_W-1:0] preset [NUM_CH];
  logic [CNT_W-1:0] count  [NUM_CH];
  logic [CNT_W-1:0] cmp    [NUM_CH];
  st_e              state    [NUM_CH];
  st_e              state_nx [NUM_CH];

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] im;
  logic [NUM_CH-1:0] w1c;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_pre;
  logic [NUM_CH-1:0] wr_cmp;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] tc;
  logic [NUM_CH-1:0] ost;
  logic [NUM_CH-1:0] ld;
  logic [NUM_CH-1:0] dec;
  logic [31:0]       rdata;

  assign word = bus.PrAddr;

  // Write decode; run reflects the CTRL value after this edge
  always_comb begin
    wr_ctrl = '0;
    wr_pre  = '0;
    wr_cmp  = '0;
    w1c     = '0;
    run     = '0;
    if (bus.Wr_en && word == 5'd16)
      w1c = bus.Data_in[NUM_CH-1:0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.Wr_en && !word[4] &&
          word[3:2] == 2'(c)) begin
        wr_ctrl[c] = word[1:0] == 2'd0;
        wr_pre[c]  = word[1:0] == 2'd1;
        wr_cmp[c]  = word[1:0] == 2'd3;
      end
      run[c] = wr_ctrl[c]
        ? (bus.Data_in[0] &&
           bus.Data_in[2:1] != M_RSV)
        : (ctrl[c][0] &&
           ctrl[c][2:1] != M_RSV);
    end
  end

  // Channel FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++)
        state[c] <= S_IDLE;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        state[c] <= state_nx[c];
    end
  end

  // Channel FSM next-state logic
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_nx[c] = state[c];
      unique case (state[c])
        S_IDLE:
          if (run[c]) state_nx[c] = S_LOAD;
        S_LOAD:
          state_nx[c] =
            (!run[c] || preset[c] == C_ZERO)
            ? S_IDLE : S_CNT;
        S_CNT:
          if (!run[c] ||
              (count[c] == C_ONE &&
               ctrl[c][2:1] == M_ONE))
            state_nx[c] = S_IDLE;
        default:
          state_nx[c] = S_IDLE;
      endcase
    end
  end

  // Channel FSM outputs: load, decrement, terminal strobes
  always_comb begin
    tc  = '0;
    ost = '0;
    ld  = '0;
    dec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      unique case (1'b1)
        state[c] == S_LOAD && run[c]: begin
          ld[c]  = 1'b1;
          tc[c]  = preset[c] == C_ZERO;
          ost[c] = preset[c] == C_ZERO;
        end
        state[c] == S_CNT && run[c] &&
        count[c] == C_ONE: begin
          tc[c]  = 1'b1;
          ost[c] = ctrl[c][2:1] == M_ONE;
          ld[c]  = ctrl[c][2:1] != M_ONE;
        end
        state[c] == S_CNT && run[c] &&
        count[c] != C_ONE:
          dec[c] = 1'b1;
        default: ;
      endcase
    end
  end

  // Registers, counters, pending bits and PWM outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend    <= '0;
      pwm_out <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ctrl[c]   <= '0;
        preset[c] <= '0;
        count[c]  <= '0;
        cmp[c]    <= '0;
      end
    end else begin
      pend <= (pend & ~w1c) | tc;
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ctrl[c])
          ctrl[c] <= bus.Data_in[3:0];
        else if (ost[c])
          ctrl[c][0] <= 1'b0;
        if (wr_pre[c])
          preset[c] <= bus.Data_in[CNT_W-1:0];
        if (wr_cmp[c])
          cmp[c] <= bus.Data_in[CNT_W-1:0];
        if (ost[c])
          count[c] <= '0;
        else if (ld[c])
          count[c] <= preset[c];
        else if (dec[c])
          count[c] <= count[c] - C_ONE;
        pwm_out[c] <= state[c] == S_CNT &&
                      ctrl[c][2:1] == M_PWM &&
                      count[c] > cmp[c];
      end
    end
  end

  // Combinational read mux and interrupt mask
  always_comb begin
    rdata = '0;
    im    = '0;
    if (word == 5'd16)
      rdata[NUM_CH-1:0] = pend;
    for (int c = 0; c < NUM_CH; c++) begin
      im[c] = ctrl[c][3];
      if (!word[4] && word[3:2] == 2'(c)) begin
        unique case (word[1:0])
          2'd0:    rdata = {28'd0, ctrl[c]};
          2'd1:    rdata = 32'(preset[c]);
          2'd2:    rdata = 32'(count[c]);
          default: rdata = 32'(cmp[c]);
        endcase
      end
    end
  end

  assign bus.Data_out = rdata;
  assign IRQ = |(pend & im);

endmodule

// File: tb/tb_multi_timer.sv
// Randomised scoreboard bench for multi_timer against
// a behavioural model of the register window.
module tb_multi_timer;

  localparam int NCH = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           IRQ;
  logic [NCH-1:0] pwm_out;

  multi_timer_if bus ();

  multi_timer #(
    .NUM_CH(NCH),
    .CNT_W (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .IRQ    (IRQ),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             a;
    logic [31:0]    d;
    logic           irq;
    logic [NCH-1:0] pwm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // model: phase 0 idle, 1 about to load, 2 counting
  logic [3:0]     m_ctrl [NCH];
  logic [31:0]    m_pre  [NCH];
  logic [31:0]    m_cnt  [NCH];
  logic [31:0]    m_cmp  [NCH];
  int             m_ph   [NCH];
  logic [NCH-1:0] m_pend;
  logic [NCH-1:0] m_pwm;

  task automatic m_reset();
    m_pend = '0;
    m_pwm  = '0;
    for (int c = 0; c < NCH; c++) begin
      m_ctrl[c] = '0;
      m_pre[c]  = '0;
      m_cnt[c]  = '0;
      m_cmp[c]  = '0;
      m_ph[c]   = 0;
    end
  endtask

  function automatic logic [31:0] m_read(int a);
    int c;
    if (a == 16) return 32'(m_pend);
    if (a < 4 * NCH) begin
      c = a / 4;
      case (a % 4)
        0:       return {28'd0, m_ctrl[c]};
        1:       return m_pre[c];
        2:       return m_cnt[c];
        default: return m_cmp[c];
      endcase
    end
    return 32'd0;
  endfunction

  function automatic logic m_irq();
    logic r;
    r = 1'b0;
    for (int c = 0; c < NCH; c++)
      r = r | (m_pend[c] & m_ctrl[c][3]);
    return r;
  endfunction

  task automatic m_step(int wr, int a,
                        logic [31:0] d);
    logic [NCH-1:0] np;
    logic [3:0]     cn;
    logic [1:0]     mode;
    bit             wc, go, tcv, one;
    np = m_pend;
    for (int c = 0; c < NCH; c++) begin
      wc   = wr != 0 && a == 4 * c;
      cn   = wc ? d[3:0] : m_ctrl[c];
      go   = cn[0] && cn[2:1] != 2'd3;
      mode = m_ctrl[c][2:1];
      tcv  = 0;
      one  = 0;
      m_pwm[c] = m_ph[c] == 2 && mode == 2'd2 &&
                 m_cnt[c] > m_cmp[c];
      if (m_ph[c] == 0) begin
        if (go) m_ph[c] = 1;
      end else if (!go) begin
        m_ph[c] = 0;
      end else if (m_ph[c] == 1) begin
        m_cnt[c] = m_pre[c];
        if (m_pre[c] == 0) begin
          tcv = 1;
          one = 1;
          m_ph[c] = 0;
        end else begin
          m_ph[c] = 2;
        end
      end else if (m_cnt[c] == 1) begin
        tcv = 1;
        if (mode == 2'd0) begin
          one = 1;
          m_cnt[c] = 0;
          m_ph[c] = 0;
        end else begin
          m_cnt[c] = m_pre[c];
        end
      end else begin
        m_cnt[c] = m_cnt[c] - 1;
      end
      m_ctrl[c] = cn;
      if (one && !wc) m_ctrl[c][0] = 1'b0;
      if (wr != 0 && a == 16 && d[c]) np[c] = 0;
      if (tcv) np[c] = 1;
      if (wr != 0 && a == 4 * c + 1) m_pre[c] = d;
      if (wr != 0 && a == 4 * c + 3) m_cmp[c] = d;
    end
    m_pend = np;
  endtask

  // One bus cycle: queue the expected read, then clock
  task automatic cyc(int wr, int a, int d);
    exp_t e;
    bus.PrAddr  = 5'(a);
    bus.Wr_en   = wr != 0;
    bus.Data_in = d;
    e.a   = a;
    e.d   = m_read(a);
    e.irq = m_irq();
    e.pwm = m_pwm;
    sb.push_back(e);
    @(posedge clk);
    if (reset) m_step(wr, a, d);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    m_reset();
    for (int a = 0; a < 18; a++)
      cyc(0, a, 0);
    cyc(0, 20, 0);
    reset = 1'b1;
  endtask

  task automatic wait_tc(int c);
    for (int k = 0; k < 40; k++) begin
      if (m_ph[c] == 2 && m_cnt[c] == 1) break;
      cyc(0, 4 * c + 2, 0);
    end
  endtask

  // Monitor: compare DUT outputs with queued expectations
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks += 3;
        if (bus.Data_out !== e.d) begin
          errors++;
          $display("FAIL rd[%0d] got %h exp %h",
                   e.a, bus.Data_out, e.d);
        end
        if (IRQ !== e.irq) begin
          errors++;
          $display("FAIL irq got %b exp %b",
                   IRQ, e.irq);
        end
        if (pwm_out !== e.pwm) begin
          errors++;
          $display("FAIL pwm got %b exp %b",
                   pwm_out, e.pwm);
        end
      end
    end
  end

  initial begin
    int r, a, ch, sel, d;
    bus.PrAddr  = '0;
    bus.Wr_en   = 1'b0;
    bus.Data_in = '0;
    m_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++)
      cyc(0, i, 0);
    reset = 1'b1;

    // one-shot with IM
    cyc(1, 1, 5);
    cyc(1, 0, 'h9);
    for (int i = 0; i < 9; i++) cyc(0, 2, 0);
    cyc(0, 0, 0);
    cyc(0, 16, 0);

    // auto-reload on ch1 and W1C
    cyc(1, 5, 3);
    cyc(1, 4, 'hB);
    for (int i = 0; i < 10; i++) cyc(0, 16, 0);
    cyc(1, 16, 2);
    for (int i = 0; i < 5; i++) cyc(0, 16, 0);

    // W1C on the exact terminal edge of ch0
    cyc(1, 16, 3);
    cyc(1, 1, 4);
    cyc(1, 0, 'hB);
    wait_tc(0);
    cyc(1, 16, 1);
    cyc(0, 16, 0);

    // CTRL write on a one-shot terminal edge
    cyc(1, 0, 'h9);
    cyc(1, 0, 'h9);
    wait_tc(0);
    cyc(1, 0, 'hB);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0);

    // PWM then EN cleared
    cyc(1, 0, 0);
    cyc(1, 1, 10);
    cyc(1, 3, 3);
    cyc(1, 0, 'h5);
    for (int i = 0; i < 25; i++) cyc(0, 2, 0);
    cyc(1, 0, 'h4);
    for (int i = 0; i < 3; i++) cyc(0, 2, 0);

    // PRESET=0 in auto-reload, COUNT write ignored
    cyc(1, 16, 3);
    cyc(1, 1, 0);
    cyc(1, 0, 'hB);
    for (int i = 0; i < 5; i++) cyc(0, 16, 0);
    cyc(0, 0, 0);
    cyc(1, 2, 'h55);
    cyc(0, 2, 0);

    // reset while both channels count
    cyc(1, 1, 7);
    cyc(1, 0, 'hB);
    cyc(1, 4, 'hB);
    for (int i = 0; i < 4; i++) cyc(0, 2, 0);
    do_reset();

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      a = int'($urandom_range(0, 31));
      if (r < 60) begin
        cyc(0, a, 0);
      end else if (r < 68) begin
        cyc(1, 16, int'($urandom_range(0, 3)));
      end else begin
        ch  = int'($urandom_range(0, NCH));
        sel = int'($urandom_range(0, 3));
        if (sel == 0) d = int'($urandom);
        else d = int'($urandom_range(0, 12));
        cyc(1, 4 * ch + sel, d);
      end
      if (i % 1000 == 999) do_reset();
    end
    cyc(0, 16, 0);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d exp 0",
               sb.size());
    end
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
